// File: rtl/nand_gate_if.sv
// Operand/result bundle for the NAND primitive and its clocked self-check side-band.
interface nand_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Y_q;
  logic [CNT_W-1:0] toggle_cnt;
  logic [3:0]       cov_seen;
  logic             cov_full;

  modport master (output A, B, input Y, Y_q, toggle_cnt, cov_seen, cov_full);
  modport slave  (input A, B, output Y, Y_q, toggle_cnt, cov_seen, cov_full);
endinterface

// File: rtl/nand_gate.sv
// Bitwise NAND base cell: combinational Y plus a registered copy, a saturating
// output-toggle counter and sticky bit-0 truth-table coverage flags.
module nand_lane (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  output logic y,
  output logic y_q
);
  // A 0 on either input forces 1 even when the other input is X/Z.
  assign y = ~(a & b);

  always_ff @(posedge clk) begin
    if (rst) y_q <= 1'b1;
    else     y_q <= y;
  end
endmodule

module nand_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  nand_gate_if.slave  bus
);
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] toggle_cnt;
  logic [3:0]       cov_seen;
  logic [3:0]       cov_hit;
  logic             toggle;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    nand_lane u_lane (
      .clk (clk),
      .rst (rst),
      .a   (bus.A[i]),
      .b   (bus.B[i]),
      .y   (y[i]),
      .y_q (y_q[i])
    );
  end

  // y is the value y_q loads at the next edge, so any difference is a toggle.
  assign toggle  = |(y ^ y_q);
  assign cov_hit = 4'b0001 << {bus.A[0], bus.B[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_cnt <= '0;
      cov_seen   <= '0;
    end else begin
      if (toggle && toggle_cnt != {CNT_W{1'b1}})
        toggle_cnt <= toggle_cnt + CNT_W'(1);
      cov_seen <= cov_seen | cov_hit;
    end
  end

  assign bus.Y          = y;
  assign bus.Y_q        = y_q;
  assign bus.toggle_cnt = toggle_cnt;
  assign bus.cov_seen   = cov_seen;
  assign bus.cov_full   = &cov_seen;
endmodule

// File: tb/tb_nand_gate.sv
// Directed bench: three nand_gate configurations (1-bit, 1-bit with 2-bit counter, 8-bit).
module tb_nand_gate;
  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b1;
  logic a1 = 1'b0, b1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  int n_chk = 0;
  int n_pass = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  nand_gate_if #(.WIDTH(1), .CNT_W(16)) if1 ();
  nand_gate_if #(.WIDTH(1), .CNT_W(2))  if2 ();
  nand_gate_if #(.WIDTH(8), .CNT_W(16)) if8 ();

  assign if1.A = a1;
  assign if1.B = b1;
  assign if2.A = a1;
  assign if2.B = b1;
  assign if8.A = a8;
  assign if8.B = b8;

  nand_gate #(.WIDTH(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(if1));
  nand_gate #(.WIDTH(1), .CNT_W(2))  u2 (.clk(clk), .rst(rst), .bus(if2));
  nand_gate #(.WIDTH(8), .CNT_W(16)) u8 (.clk(clk), .rst(rst), .bus(if8));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] vec [4];
  logic [3:0] cov_exp [4];
  logic       yq_exp  [6];
  logic [1:0] sat_exp [6];

  initial begin
    vec     = '{2'b00, 2'b01, 2'b10, 2'b11};
    cov_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    yq_exp  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    // Combinational truth table with no clock, rst at both levels.
    for (int r = 0; r < 2; r++) begin
      rst = (r == 0);
      for (int i = 0; i < 4; i++) begin
        {a1, b1} = vec[i];
        #10;
        chk($sformatf("comb_y_rst%0d_%b", rst, vec[i]), 32'(if1.Y), 32'(i == 3 ? 0 : 1));
      end
    end
    a8 = 8'hF0; b8 = 8'hCC;
    #1;
    chk("comb_y8_f0cc", 32'(if8.Y), 32'h3F);

    // Random stream, then reset.
    rst = 1'b0;
    clk_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    chk("rst_yq", 32'(if1.Y_q), 32'd1);
    chk("rst_cnt", 32'(if1.toggle_cnt), 32'd0);
    chk("rst_cov", 32'(if1.cov_seen), 32'd0);
    chk("rst_full", 32'(if1.cov_full), 32'd0);
    chk("rst_yq8", 32'(if8.Y_q), 32'hFF);
    a1 = 1'b1; b1 = 1'b1;
    #1;
    chk("rst_y_tracks", 32'(if1.Y), 32'd0);
    step();
    chk("rst_hold_yq", 32'(if1.Y_q), 32'd1);
    chk("rst_hold_cov", 32'(if1.cov_seen), 32'd0);
    chk("rst_hold_cnt", 32'(if1.toggle_cnt), 32'd0);

    // Coverage sweep.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = vec[i];
      step();
      chk($sformatf("cov_seen_%b", vec[i]), 32'(if1.cov_seen), 32'(cov_exp[i]));
      chk($sformatf("cov_full_%b", vec[i]), 32'(if1.cov_full), 32'(i == 3 ? 1 : 0));
    end

    // Toggle counting from reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = (i % 2 == 0) ? 2'b11 : 2'b00;
      step();
      chk($sformatf("tog_yq_%0d", i), 32'(if1.Y_q), 32'(yq_exp[i]));
      chk($sformatf("tog_cnt_%0d", i), 32'(if1.toggle_cnt), 32'(i + 1));
    end
    step();
    step();
    chk("tog_cnt_hold", 32'(if1.toggle_cnt), 32'd4);

    // Saturation on the 2-bit counter.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      {a1, b1} = (i % 2 == 0) ? 2'b11 : 2'b00;
      step();
      chk($sformatf("sat_cnt_%0d", i), 32'(if2.toggle_cnt), 32'(sat_exp[i]));
    end
    rst = 1'b1;
    step();
    chk("sat_midrun_rst", 32'(if2.toggle_cnt), 32'd0);
    rst = 1'b0;

    // Multi-bit path.
    a8 = 8'hF0; b8 = 8'hCC;
    #1;
    chk("y8_f0cc", 32'(if8.Y), 32'h3F);
    step();
    chk("yq8_f0cc", 32'(if8.Y_q), 32'h3F);
    a8 = 8'hFF; b8 = 8'hFF;
    #1;
    chk("y8_ffff", 32'(if8.Y), 32'h00);
    chk("yq8_lag", 32'(if8.Y_q), 32'h3F);
    step();
    chk("yq8_ffff", 32'(if8.Y_q), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
